// File: rtl/nes_port_shifter.sv
// nes_port_shifter: NES/SNES console-port serializer on the latch/pulse/data protocol.
// Optional autofire on masked buttons when NES_PORT_TURBO_EN is defined.
module nes_port_shifter #(
  parameter int   BITS         = 8,
  parameter int   SYNC_STAGES  = 2,
  parameter logic FILL_BIT     = 1'b0,
  parameter int   TURBO_FRAMES = 2
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic [BITS-1:0] buttons_in,
  input  logic            latch_in,
  input  logic            pulse_in,
  input  logic [BITS-1:0] turbo_mask_in,
  output logic            data_out,
  output logic            shifting_out,
  output logic            frame_done_out
);

  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] latch_sync, pulse_sync;
  logic                   latch_q, pulse_q;
  logic                   latch_hi, latch_fall, pulse_rise;
  logic [BITS-1:0]        sr, sr_d, load_word;
  logic [CW-1:0]          cnt, cnt_d;
  logic                   done_d, done_q;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      latch_sync <= '0;
      pulse_sync <= '0;
      latch_q    <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch_in};
      pulse_sync <= {pulse_sync[SYNC_STAGES-2:0], pulse_in};
      latch_q    <= latch_sync[SYNC_STAGES-1];
      pulse_q    <= pulse_sync[SYNC_STAGES-1];
    end
  end

  assign latch_hi   = latch_sync[SYNC_STAGES-1];
  assign latch_fall = ~latch_hi & latch_q;
  assign pulse_rise = pulse_sync[SYNC_STAGES-1] & ~pulse_q;

`ifdef NES_PORT_TURBO_EN
  localparam int TW = $clog2(TURBO_FRAMES + 1);

  logic [TW-1:0] tcnt;
  logic          phase;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      tcnt  <= '0;
      phase <= 1'b0;
    end else if (latch_fall) begin
      if (tcnt == TW'(TURBO_FRAMES - 1)) begin
        tcnt  <= '0;
        phase <= ~phase;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  // Active-low word: OR-ing the mask forces autofire buttons to released.
  assign load_word = phase ? (buttons_in | turbo_mask_in) : buttons_in;
`else
  logic unused_turbo;
  assign unused_turbo = ^turbo_mask_in;
  assign load_word    = buttons_in;
`endif

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state  <= IDLE;
      sr     <= '1;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      sr     <= sr_d;
      cnt    <= cnt_d;
      done_q <= done_d;
    end
  end

  // Latch overrides everything, including a pulse edge in the same cycle.
  always_comb begin
    state_d = state;
    sr_d    = sr;
    cnt_d   = cnt;
    done_d  = 1'b0;
    if (latch_hi) begin
      state_d = LOAD;
      sr_d    = load_word;
      cnt_d   = '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (latch_fall) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          if (pulse_rise) begin
            sr_d  = {FILL_BIT, sr[BITS-1:1]};
            cnt_d = cnt + 1'b1;
            if (cnt == CW'(BITS - 1)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign data_out       = sr[0];
  assign shifting_out   = (state == SHIFT);
  assign frame_done_out = done_q;

endmodule

// File: tb/tb_nes_port_shifter.sv
// tb_nes_port_shifter: directed + randomized checks of nes_port_shifter
// against a frame-level reference model (captured word + bit index).
module tb_nes_port_shifter;

  localparam int   BITS = 8;
  localparam int   SS   = 2;
  localparam logic FILL = 1'b0;
  localparam int   TF   = 2;

  logic            clk_in = 1'b0;
  logic            reset_in = 1'b0;
  logic [BITS-1:0] buttons_in = '1;
  logic            latch_in = 1'b0;
  logic            pulse_in = 1'b0;
  logic [BITS-1:0] turbo_mask_in = '0;
  logic            data_out, shifting_out, frame_done_out;

  nes_port_shifter #(
    .BITS(BITS),
    .SYNC_STAGES(SS),
    .FILL_BIT(FILL),
    .TURBO_FRAMES(TF)
  ) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .buttons_in(buttons_in),
    .latch_in(latch_in),
    .pulse_in(pulse_in),
    .turbo_mask_in(turbo_mask_in),
    .data_out(data_out),
    .shifting_out(shifting_out),
    .frame_done_out(frame_done_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_seen  = 0;
  int fd_exp   = 0;

  always @(negedge clk_in) if (frame_done_out === 1'b1) fd_seen++;

  logic [BITS-1:0] word;
  int              idx;
  bit              in_frame;
  int              nfalls;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_data();
    if (!in_frame) return 1'b1;
    if (idx < BITS) return word[idx];
    return FILL;
  endfunction

  function automatic logic [BITS-1:0] capture(input logic [BITS-1:0] b);
`ifdef NES_PORT_TURBO_EN
    if (((nfalls / TF) % 2) == 1) return b | turbo_mask_in;
`endif
    return b;
  endfunction

  task automatic latch_frame(input logic [BITS-1:0] b, input bit with_pulse);
    logic [BITS-1:0] cap;
    latch_in   = 1'b1;
    pulse_in   = with_pulse;
    buttons_in = BITS'($urandom);
    tick(2);
    buttons_in = b;
    cap = capture(b);
    tick(3);
    check("load_data", data_out, cap[0]);
    check("load_shift", shifting_out, 1'b0);
    latch_in = 1'b0;
    pulse_in = 1'b0;
    tick(2);
    check("fall_lat_lo", shifting_out, 1'b0);
    tick(1);
    check("fall_lat_hi", shifting_out, 1'b1);
    check("first_bit", data_out, cap[0]);
    word       = cap;
    idx        = 0;
    in_frame   = 1'b1;
    nfalls++;
    buttons_in = BITS'($urandom);
  endtask

  task automatic pulse_once();
    logic old;
    bit   fire;
    old      = exp_data();
    fire     = 1'b0;
    pulse_in = 1'b1;
    tick(2);
    check("pulse_hold", data_out, old);
    if (in_frame && idx < BITS) begin
      idx++;
      fire = (idx == BITS);
    end
    if (fire) fd_exp++;
    tick(1);
    check("pulse_data", data_out, exp_data());
    check("pulse_done", frame_done_out, fire);
    check("pulse_shift", shifting_out, in_frame && idx < BITS);
    pulse_in = 1'b0;
    tick(1);
    check("done_1cyc", frame_done_out, 1'b0);
    tick(2);
  endtask

  initial begin
    logic [5:0] turbo_tbl;
    logic [7:0] abort_w;
    in_frame = 1'b0;
    idx      = 0;
    nfalls   = 0;
    word     = '1;

    for (int i = 0; i < 8; i++) begin
      latch_in = i[0];
      pulse_in = i[1];
      tick(1);
      check("rst_data", data_out, 1'b1);
      check("rst_shift", shifting_out, 1'b0);
      check("rst_done", frame_done_out, 1'b0);
    end
    latch_in = 1'b0;
    pulse_in = 1'b0;
    #2 reset_in = 1'b1;
    tick(3);

    for (int i = 0; i < 2; i++) pulse_once();

    latch_frame(8'hFE, 1'b0);
    for (int i = 0; i < 10; i++) pulse_once();
    check("basic_fd", fd_seen, fd_exp);

    latch_frame(8'h5A, 1'b0);
    for (int i = 0; i < 3; i++) pulse_once();
    abort_w = 8'h5A;
    latch_frame(abort_w, 1'b0);
    check("abort_fd", fd_seen, fd_exp);
    for (int i = 0; i < BITS; i++) begin
      check("abort_bit", data_out, abort_w[i]);
      pulse_once();
    end
    check("abort_fill", data_out, FILL);

    latch_frame(8'hA5, 1'b1);
    check("collide", data_out, 1'b1);
    pulse_once();
    check("collide_b1", data_out, 1'b0);

    reset_in = 1'b0;
    #2 reset_in = 1'b1;
    in_frame = 1'b0;
    nfalls   = 0;
    tick(3);
    turbo_mask_in = 8'h01;
`ifdef NES_PORT_TURBO_EN
    turbo_tbl = 6'b001100;
`else
    turbo_tbl = 6'b000000;
`endif
    for (int k = 0; k < 6; k++) begin
      latch_frame(8'hFE, 1'b0);
      check("turbo_bit0", data_out, turbo_tbl[k]);
    end

    for (int f = 0; f < 8; f++) begin
      turbo_mask_in = BITS'($urandom);
      latch_frame(BITS'($urandom), 1'b0);
      for (int p = 0; p < int'($urandom_range(0, 11)); p++) pulse_once();
    end
    check("rand_fd", fd_seen, fd_exp);

    latch_frame(8'h00, 1'b0);
    pulse_once();
    #3 reset_in = 1'b0;
    #1;
    check("mid_rst_data", data_out, 1'b1);
    check("mid_rst_shift", shifting_out, 1'b0);
    check("mid_rst_done", frame_done_out, 1'b0);
    tick(2);
    reset_in = 1'b1;
    in_frame = 1'b0;
    nfalls   = 0;
    tick(3);
    pulse_once();
    check("post_rst_idle", shifting_out, 1'b0);
    latch_frame(8'h3C, 1'b0);
    for (int i = 0; i < BITS; i++) pulse_once();
    check("final_fd", fd_seen, fd_exp);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
